// File: rtl/stepper_move_ctrl_if.sv
// Command/status bundle between the move sequencer and its user logic.
// Field names match the original flat port list.
interface stepper_move_ctrl_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned DIV_W = 8,
    parameter int unsigned POS_W = 16
);
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] steps;
    logic [DIV_W-1:0] period;
    logic             abort;
    logic             step_en;
    logic             UpDown;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [1:0]       phase;
    logic [POS_W-1:0] position;

    modport master (
        output start, dir, steps, period, abort,
        input  step_en, UpDown, busy, done, aborted, phase, position
    );

    modport slave (
        input  start, dir, steps, period, abort,
        output step_en, UpDown, busy, done, aborted, phase, position
    );
endinterface

// File: rtl/stepper_move_ctrl.sv
// Move sequencer for the 2-bit up/down stepper phase counter: issues paced step
// strobes, mirrors the counter phase and tracks a signed absolute position.
module stepper_move_ctrl #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned DIV_W = 8,
    parameter int unsigned POS_W = 16
) (
    input logic                stepClk,
    input logic                reset,
    stepper_move_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] rem_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] per_q;
    logic             step_en_q;
    logic             updown_q;
    logic             done_q;
    logic             aborted_q;
    logic             abort_hit_q;
    logic [1:0]       phase_q, phase_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [DIV_W-1:0] per_acc;

    always_comb begin
        per_acc = (bus.period == '0) ? DIV_W'(1) : bus.period;
    end

    // Phase/position follow the strobe one edge later, exactly as the counter does.
    always_comb begin
        phase_d = phase_q;
        pos_d   = pos_q;
        if (step_en_q) begin
            if (updown_q) begin
                phase_d = phase_q - 2'd1;
                pos_d   = pos_q - POS_W'(1);
            end else begin
                phase_d = phase_q + 2'd1;
                pos_d   = pos_q + POS_W'(1);
            end
        end
    end

    always_ff @(posedge stepClk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            div_q       <= '0;
            per_q       <= '0;
            step_en_q   <= 1'b0;
            updown_q    <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            abort_hit_q <= 1'b0;
            phase_q     <= '0;
            pos_q       <= '0;
        end else begin
            phase_q   <= phase_d;
            pos_q     <= pos_d;
            done_q    <= 1'b0;
            step_en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        updown_q    <= bus.dir;
                        rem_q       <= bus.steps;
                        per_q       <= per_acc;
                        div_q       <= per_acc - DIV_W'(1);
                        aborted_q   <= 1'b0;
                        abort_hit_q <= 1'b0;
                        state_q     <= (bus.steps != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        abort_hit_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (div_q != '0) begin
                        div_q <= div_q - DIV_W'(1);
                    end else begin
                        step_en_q <= 1'b1;
                        div_q     <= per_q - DIV_W'(1);
                        rem_q     <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q    <= 1'b1;
                    aborted_q <= abort_hit_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.step_en  = step_en_q;
    assign bus.UpDown   = updown_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.aborted  = aborted_q;
    assign bus.phase    = phase_q;
    assign bus.position = pos_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Bench for stepper_move_ctrl: directed table, hand sequences and randomized moves
// checked against a step-schedule model.
module tb_stepper_move_ctrl;
    localparam int CNT_W = 8;
    localparam int DIV_W = 8;
    localparam int POS_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    stepper_move_ctrl_if #(.CNT_W(CNT_W), .DIV_W(DIV_W), .POS_W(POS_W)) bus();

    stepper_move_ctrl #(.CNT_W(CNT_W), .DIV_W(DIV_W), .POS_W(POS_W)) dut (
        .stepClk (clk),
        .reset   (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state: accumulated phase and position over all completed moves.
    int          m_phase;
    logic [15:0] m_pos;

    typedef struct {
        bit rst;
        bit d;
        int n;
        int per;
        int ab_t;
        int done_t;
        int ph;
        int pos;
        bit ab;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.dir    = 1'b0;
        bus.steps  = '0;
        bus.period = '0;
        tick();
        tick();
        rst_n   = 1'b1;
        m_phase = 0;
        m_pos   = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_step_en"},  bus.step_en,  0);
        chk({tag, "_UpDown"},   bus.UpDown,   0);
        chk({tag, "_busy"},     bus.busy,     0);
        chk({tag, "_done"},     bus.done,     0);
        chk({tag, "_aborted"},  bus.aborted,  0);
        chk({tag, "_phase"},    bus.phase,    0);
        chk({tag, "_position"}, bus.position, 0);
    endtask

    // Step k (1..nst) is visible in the cycle P*k edges after accept; done is the
    // edge after the last RUN edge (or after the abort edge).
    task automatic run_move(input bit d, input int n, input int per, input int ab_t,
                            input int poke_t, output int done_t, output int ph,
                            output int pos, output bit ab);
        int P, tdone, nst, delta;
        bit exp_ab;
        P = (per == 0) ? 1 : per;
        if (ab_t > 0 && ab_t <= P * n) begin
            tdone  = ab_t + 1;
            nst    = (ab_t - 1) / P;
            exp_ab = 1'b1;
        end else begin
            tdone  = (n == 0) ? 1 : P * n + 1;
            nst    = n;
            exp_ab = 1'b0;
        end
        bus.start  = 1'b1;
        bus.dir    = d;
        bus.steps  = n[7:0];
        bus.period = per[7:0];
        bus.abort  = 1'b0;
        tick();
        bus.start  = 1'b0;
        bus.dir    = 1'($urandom);
        bus.steps  = 8'($urandom);
        bus.period = 8'($urandom);
        chk("busy_after_accept", bus.busy, 1);
        chk("aborted_cleared", bus.aborted, 0);
        done_t = -1;
        ph     = 0;
        pos    = 0;
        ab     = 1'b0;
        for (int t = 1; t <= tdone + 2 && done_t < 0; t++) begin
            bus.abort = (t == ab_t);
            bus.start = (t == poke_t);
            tick();
            chk("step_en", bus.step_en, (t % P == 0 && t / P >= 1 && t / P <= nst));
            chk("busy", bus.busy, (t < tdone));
            if (bus.done) begin
                done_t = t;
                ph     = bus.phase;
                pos    = bus.position;
                ab     = bus.aborted;
            end
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        delta   = d ? -nst : nst;
        m_pos   = m_pos + 16'(delta);
        m_phase = (((m_phase + delta) % 4) + 4) % 4;
        chk("done_time", done_t, tdone);
        chk("aborted", ab, exp_ab);
        chk("phase", ph, m_phase);
        chk("position", pos, m_pos);
        chk("UpDown_hold", bus.UpDown, d);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dt, ph, pos;
        bit ab;
        bit exp_busy[5];
        bit exp_done[5];
        bit exp_step[5];

        vt[0] = '{rst: 1, d: 0, n: 4,  per: 3, ab_t: 0, done_t: 13, ph: 0, pos: 'h0004, ab: 0};
        vt[1] = '{rst: 1, d: 1, n: 3,  per: 1, ab_t: 0, done_t: 4,  ph: 1, pos: 'hFFFD, ab: 0};
        vt[2] = '{rst: 0, d: 0, n: 2,  per: 0, ab_t: 0, done_t: 3,  ph: 3, pos: 'hFFFF, ab: 0};
        vt[3] = '{rst: 0, d: 0, n: 0,  per: 5, ab_t: 0, done_t: 1,  ph: 3, pos: 'hFFFF, ab: 0};
        vt[4] = '{rst: 1, d: 0, n: 10, per: 2, ab_t: 5, done_t: 6,  ph: 2, pos: 'h0002, ab: 1};
        vt[5] = '{rst: 0, d: 1, n: 5,  per: 1, ab_t: 1, done_t: 2,  ph: 2, pos: 'h0002, ab: 1};
        vt[6] = '{rst: 0, d: 1, n: 2,  per: 3, ab_t: 0, done_t: 7,  ph: 0, pos: 'h0000, ab: 0};

        do_reset();
        chk_all_zero("reset");

        for (int i = 0; i < 7; i++) begin
            if (vt[i].rst) do_reset();
            run_move(vt[i].d, vt[i].n, vt[i].per, vt[i].ab_t, 0, dt, ph, pos, ab);
            chk($sformatf("vec%0d_done_t", i), dt, vt[i].done_t);
            chk($sformatf("vec%0d_phase", i), ph, vt[i].ph);
            chk($sformatf("vec%0d_position", i), pos, vt[i].pos);
            chk($sformatf("vec%0d_aborted", i), ab, vt[i].ab);
        end

        // Start pulsed mid-move is ignored; original count of 3 completes.
        do_reset();
        run_move(1'b0, 3, 2, 0, 3, dt, ph, pos, ab);
        chk("busy_start_ignored_pos", pos, 3);

        // Reset mid-move drops everything, no done afterwards.
        do_reset();
        bus.start  = 1'b1;
        bus.dir    = 1'b1;
        bus.steps  = 8'd5;
        bus.period = 8'd2;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_reset_busy", bus.busy, 1);
        chk("pre_reset_position", bus.position, 16'hFFFF);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_all_zero("midreset");
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midreset_no_done", bus.done, 0);
            chk("midreset_idle", bus.busy, 0);
        end
        m_phase = 0;
        m_pos   = '0;

        // start held high across done: re-accept right after the done cycle.
        exp_busy = '{1, 0, 1, 1, 0};
        exp_done = '{0, 1, 0, 0, 1};
        exp_step = '{1, 0, 0, 1, 0};
        bus.start  = 1'b1;
        bus.dir    = 1'b0;
        bus.steps  = 8'd1;
        bus.period = 8'd1;
        tick();
        for (int t = 1; t <= 5; t++) begin
            if (t == 4) bus.start = 1'b0;
            tick();
            chk($sformatf("b2b_busy_t%0d", t), bus.busy, exp_busy[t-1]);
            chk($sformatf("b2b_done_t%0d", t), bus.done, exp_done[t-1]);
            chk($sformatf("b2b_step_t%0d", t), bus.step_en, exp_step[t-1]);
            bus.start = (t < 3);
        end
        chk("b2b_position", bus.position, 2);
        chk("b2b_phase", bus.phase, 2);
        m_phase = 2;
        m_pos   = 16'd2;

        // Randomized moves against the schedule model.
        for (int i = 0; i < 40; i++) begin
            int n, per, P, ab_t, poke_t;
            bit d;
            d      = 1'($urandom);
            n      = $urandom_range(0, 12);
            per    = $urandom_range(0, 5);
            P      = (per == 0) ? 1 : per;
            ab_t   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, P * n + 2) : 0;
            poke_t = ($urandom_range(0, 3) == 0) ? $urandom_range(1, P * n + 1) : 0;
            run_move(d, n, per, ab_t, poke_t, dt, ph, pos, ab);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Position wrap across the signed boundary.
        do_reset();
        for (int i = 0; i < 128; i++) run_move(1'b0, 255, 1, 0, 0, dt, ph, pos, ab);
        run_move(1'b0, 127, 1, 0, 0, dt, ph, pos, ab);
        chk("pos_7fff", pos, 16'h7FFF);
        run_move(1'b0, 1, 1, 0, 0, dt, ph, pos, ab);
        chk("pos_8000", pos, 16'h8000);
        chk("phase_after_wrap", ph, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
